// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell walks the operands LSB-first with a
// registered carry, then publishes {cout,sum} alongside a one-cycle done pulse.

module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic             r_carry;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_done;
  logic             w_load;
  logic             w_last;
  logic             w_fa_s;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_s_shift;

  full_adder u_fa (
    .x    (r_a_sr[0]),
    .y    (r_b_sr[0]),
    .cin  (r_carry),
    .s    (w_fa_s),
    .cout (w_fa_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at [0]
  assign w_s_shift = {w_fa_s, r_s_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_count == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_a_sr  <= a;
        r_b_sr  <= b;
        r_carry <= cin;
        r_count <= '0;
      end else if (r_state == RUN) begin
        r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
        r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
        r_s_sr  <= w_s_shift;
        r_carry <= w_fa_cout;
        r_count <= r_count + CNT_W'(1);
        if (w_last) begin
          r_sum  <= w_s_shift;
          r_cout <= w_fa_cout;
        end
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder: an 8-bit instance for directed cases and
// back-to-back issue, plus a 4-bit instance swept over every (a,b,cin).

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done8_cnt = 0;
  int done4_cnt = 0;
  int last_done8 = -1;
  bit b2b_chk = 1'b0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done8) begin
      done8_cnt++;
      if (b2b_chk && last_done8 >= 0) chk("b2b_period", cyc - last_done8, 9);
      last_done8 = cyc;
      if (q8.size() == 0) chk("spurious_done8", 1, 0);
      else chk("result8", {cout8, sum8}, q8.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4) begin
      done4_cnt++;
      if (q4.size() == 0) chk("spurious_done4", 1, 0);
      else chk("result4", {cout4, sum4}, q4.pop_front());
    end
  end

  function automatic logic [8:0] exp8(input logic [7:0] a, input logic [7:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {8'd0, c};
  endfunction

  // Leaves the caller at the falling edge just after the accepting edge.
  task automatic start8_pulse(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back(exp8(a, b, c));
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done8) chk("timeout_done8", 0, 1);
  endtask

  initial begin
    int d0;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    rst_n = 1'b1;

    // Zero sum with cycle-exact busy/done timing
    start8_pulse(8'h00, 8'h00, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 8) begin
        chk("t1_busy_run", busy8, 1);
        chk("t1_done_low", done8, 0);
      end else begin
        chk("t1_done_pulse", done8, 1);
        chk("t1_busy_idle", busy8, 0);
      end
    end
    @(negedge clk);
    chk("t1_done_one_cycle", done8, 0);

    // Carry ripple
    start8_pulse(8'hFF, 8'h01, 1'b0);
    wait_done8();
    chk("t2a_sum", sum8, 8'h00);
    chk("t2a_cout", cout8, 1);
    @(negedge clk);
    start8_pulse(8'hFF, 8'hFF, 1'b1);
    wait_done8();
    chk("t2b_sum", sum8, 8'hFF);
    chk("t2b_cout", cout8, 1);

    // Mixed with cin, then hold through idle cycles
    @(negedge clk);
    start8_pulse(8'h5A, 8'h3C, 1'b1);
    wait_done8();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t3_hold", {cout8, sum8}, 9'h097);
    end

    // Start while busy is ignored
    d0 = done8_cnt;
    start8_pulse(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();
    repeat (15) @(negedge clk);
    chk("t4_single_done", done8_cnt - d0, 1);
    chk("t4_sum", sum8, 8'h30);
    chk("t4_cout", cout8, 0);

    // Reset mid-operation aborts and clears
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_busy", busy8, 0);
    chk("t5_done", done8, 0);
    chk("t5_sum", sum8, 0);
    chk("t5_cout", cout8, 0);
    start8_pulse(8'h01, 8'h01, 1'b0);
    wait_done8();
    chk("t5_after_sum", sum8, 8'h02);

    // Back-to-back issue with start held high
    repeat (3) @(negedge clk);
    d0 = done8_cnt;
    b2b_chk = 1'b1;
    last_done8 = -1;
    start8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      q8.push_back(exp8(a8, b8, cin8));
      repeat (9) @(negedge clk);
    end
    start8 = 1'b0;
    @(negedge clk);
    b2b_chk = 1'b0;
    chk("t6_b2b_count", done8_cnt - d0, 6);

    // Exhaustive sweep on the 4-bit instance
    start4 = 1'b1;
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      vv = 9'(v);
      a4 = vv[3:0]; b4 = vv[7:4]; cin4 = vv[8];
      q4.push_back({1'b0, vv[3:0]} + {1'b0, vv[7:4]} + {4'd0, vv[8]});
      repeat (5) @(negedge clk);
    end
    start4 = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_w4_count", done4_cnt, 512);
    chk("q8_empty", q8.size(), 0);
    chk("q4_empty", q4.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
